wb_arbiter: RTL and testbench

- Sits directly downstream of the execution stage. Consumes its 8-lane writeback bus: wb_valid/data/dest/rob_idx plus br_mispredict/br_target.
- Buffers each lane in a small per-lane FIFO and arbitrates round-robin onto NUM_PORTS physical-register-file write ports and ROB completion ports.
- Forwards branch mispredicts to the front-end as a registered redirect.
- Reports per-lane almost-full so issue logic can throttle the corresponding functional unit.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_lane_fifo.sv | 78 +++++++
 rtl/wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback types and constants for the writeback arbiter and its lane FIFOs.
package wb_pkg;

   localparam int unsigned NUM_WB_LANES = 8;
   localparam int unsigned BRANCH_LANE  = 7;
   localparam int unsigned DATA_W       = 64;
   localparam int unsigned PREG_W       = 7;
   localparam int unsigned ROB_W        = 8;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [PREG_W-1:0] dest;
      logic [ROB_W-1:0]  rob;
   } wb_entry_t;

endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane writeback FIFO: registered count and almost-full, drop indication when
// a push hits a full FIFO that is not popping in the same cycle.
module wb_lane_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  wb_entry_t        din,
   output wb_entry_t        head_c,
   output logic [CNT_W-1:0] count,
   output logic             afull,
   output logic             drop_c
);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   wb_entry_t        mem [DEPTH];
   logic             empty_c;
   logic             full_c;
   logic             do_pop_c;
   logic             do_push_c;
   logic [CNT_W-1:0] count_nxt_c;

   assign empty_c   = (count == '0);
   assign full_c    = (count == CNT_W'(DEPTH));
   assign do_pop_c  = pop && !empty_c;
   // A full FIFO still accepts a push when it pops in the same cycle.
   assign do_push_c = push && (!full_c || do_pop_c);
   assign drop_c    = push && full_c && !do_pop_c;
   assign head_c    = mem[rd_ptr];

   always_comb begin
      count_nxt_c = count;
      if (do_push_c && !do_pop_c) begin
         count_nxt_c = count + CNT_W'(1);
      end else if (!do_push_c && do_pop_c) begin
         count_nxt_c = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         afull  <= 1'b0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         afull  <= 1'b0;
      end else begin
         if (do_pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         count <= count_nxt_c;
         afull <= (count_nxt_c >= CNT_W'(DEPTH - 1));
      end
   end

   // Storage needs no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push_c && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-lane FIFOs drained round-robin onto PRF write / ROB completion
// ports, plus a registered branch redirect. WB_ARB_BYPASS_EN lets empty lanes bypass their FIFO.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned NUM_LANES  = NUM_WB_LANES,
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush_i,
   input  logic [NUM_LANES-1:0]          wb_valid,
   input  logic [DATA_W*NUM_LANES-1:0]   wb_data,
   input  logic [PREG_W*NUM_LANES-1:0]   wb_dest,
   input  logic [ROB_W*NUM_LANES-1:0]    wb_rob_idx,
   input  logic [NUM_LANES-1:0]          br_mispredict,
   input  logic [DATA_W*NUM_LANES-1:0]   br_target,
   output logic [NUM_PORTS-1:0]          prf_we_o,
   output logic [PREG_W*NUM_PORTS-1:0]   prf_waddr_o,
   output logic [DATA_W*NUM_PORTS-1:0]   prf_wdata_o,
   output logic [NUM_PORTS-1:0]          rob_cmpl_valid_o,
   output logic [ROB_W*NUM_PORTS-1:0]    rob_cmpl_idx_o,
   output logic                          redirect_valid_o,
   output logic [DATA_W-1:0]             redirect_target_o,
   output logic [ROB_W-1:0]              redirect_rob_o,
   output logic [NUM_LANES-1:0]          lane_afull_o,
   output logic                          overflow_o
);

   localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned GCNT_W = $clog2(NUM_PORTS + 1);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

   wb_entry_t              in_entry   [NUM_LANES];
   wb_entry_t              head       [NUM_LANES];
   wb_entry_t              cand_entry [NUM_LANES];
   logic [CNT_W-1:0]       fifo_count [NUM_LANES];
   logic [NUM_LANES-1:0]   fifo_empty;
   logic [NUM_LANES-1:0]   fifo_drop;
   logic [NUM_LANES-1:0]   push;
   logic [NUM_LANES-1:0]   pop;
   logic [NUM_LANES-1:0]   cand_valid;
   logic [NUM_LANES-1:0]   grant;
   logic [LANE_W-1:0]      rr_ptr;
   logic [LANE_W-1:0]      rr_nxt;
   logic [NUM_PORTS-1:0]   port_vld;
   wb_entry_t              port_entry [NUM_PORTS];
   logic [NUM_PORTS-1:0]   port_we_q;
   wb_entry_t              port_q     [NUM_PORTS];
   logic                   br_fire_c;
   logic                   unused_br;

   // Only the branch lane's mispredict/target are meaningful.
   assign unused_br = ^{br_mispredict, br_target};
   assign br_fire_c = wb_valid[BRANCH_LANE] && br_mispredict[BRANCH_LANE];

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      assign in_entry[l] = '{data: wb_data[DATA_W*l +: DATA_W],
                             dest: wb_dest[PREG_W*l +: PREG_W],
                             rob:  wb_rob_idx[ROB_W*l +: ROB_W]};
      assign fifo_empty[l] = (fifo_count[l] == '0);

      wb_lane_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk    (clk),
         .rst_n  (rst_n),
         .flush  (flush_i),
         .push   (push[l]),
         .pop    (pop[l]),
         .din    (in_entry[l]),
         .head_c (head[l]),
         .count  (fifo_count[l]),
         .afull  (lane_afull_o[l]),
         .drop_c (fifo_drop[l])
      );
   end

   // Arbitration candidates: FIFO heads, or the incoming entry of an empty lane when bypassing.
   always_comb begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         cand_valid[l] = !fifo_empty[l];
         cand_entry[l] = head[l];
`ifdef WB_ARB_BYPASS_EN
         if (fifo_empty[l] && wb_valid[l]) begin
            cand_valid[l] = 1'b1;
            cand_entry[l] = in_entry[l];
         end
`endif
      end
   end

   // Round-robin scan from rr_ptr; k-th granted lane drives port k.
   always_comb begin
      logic [LANE_W-1:0] idx;
      logic [GCNT_W-1:0] n;
      idx      = '0;
      n        = '0;
      grant    = '0;
      port_vld = '0;
      rr_nxt   = rr_ptr;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         port_entry[p] = '0;
      end
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
         idx = LANE_W'((32'(rr_ptr) + k) % NUM_LANES);
         if (cand_valid[idx] && !flush_i && (n < GCNT_W'(NUM_PORTS))) begin
            grant[idx]                = 1'b1;
            port_vld[PORT_W'(n)]      = 1'b1;
            port_entry[PORT_W'(n)]    = cand_entry[idx];
            n                         = n + GCNT_W'(1);
            rr_nxt                    = LANE_W'((32'(idx) + 32'd1) % NUM_LANES);
         end
      end
   end

   // A bypass-granted entry never enters its FIFO.
   always_comb begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         pop[l]  = grant[l] && !fifo_empty[l];
         push[l] = wb_valid[l] && !flush_i;
`ifdef WB_ARB_BYPASS_EN
         if (grant[l] && fifo_empty[l]) begin
            push[l] = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr            <= '0;
         port_we_q         <= '0;
         redirect_valid_o  <= 1'b0;
         redirect_target_o <= '0;
         redirect_rob_o    <= '0;
         overflow_o        <= 1'b0;
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_q[p] <= '0;
         end
      end else begin
         overflow_o <= overflow_o | (|fifo_drop);
         if (flush_i) begin
            rr_ptr           <= '0;
            port_we_q        <= '0;
            redirect_valid_o <= 1'b0;
         end else begin
            rr_ptr           <= rr_nxt;
            port_we_q        <= port_vld;
            redirect_valid_o <= br_fire_c;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
               port_q[p] <= port_entry[p];
            end
            if (br_fire_c) begin
               redirect_target_o <= br_target[DATA_W*BRANCH_LANE +: DATA_W];
               redirect_rob_o    <= wb_rob_idx[ROB_W*BRANCH_LANE +: ROB_W];
            end
         end
      end
   end

   assign prf_we_o         = port_we_q;
   assign rob_cmpl_valid_o = port_we_q;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign prf_waddr_o[PREG_W*p +: PREG_W]   = port_q[p].dest;
      assign prf_wdata_o[DATA_W*p +: DATA_W]   = port_q[p].data;
      assign rob_cmpl_idx_o[ROB_W*p +: ROB_W]  = port_q[p].rob;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: queue-based reference model predicts each cycle's
// port, redirect, almost-full and overflow outputs; a monitor compares them.
module tb_wb_arbiter;
   import wb_pkg::*;

   localparam int unsigned NL    = 8;
   localparam int unsigned NP    = 4;
   localparam int unsigned DEPTH = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              flush_i = 1'b0;
   logic [NL-1:0]     wb_valid = '0;
   logic [64*NL-1:0]  wb_data = '0;
   logic [7*NL-1:0]   wb_dest = '0;
   logic [8*NL-1:0]   wb_rob_idx = '0;
   logic [NL-1:0]     br_mispredict = '0;
   logic [64*NL-1:0]  br_target = '0;
   logic [NP-1:0]     prf_we_o;
   logic [7*NP-1:0]   prf_waddr_o;
   logic [64*NP-1:0]  prf_wdata_o;
   logic [NP-1:0]     rob_cmpl_valid_o;
   logic [8*NP-1:0]   rob_cmpl_idx_o;
   logic              redirect_valid_o;
   logic [63:0]       redirect_target_o;
   logic [7:0]        redirect_rob_o;
   logic [NL-1:0]     lane_afull_o;
   logic              overflow_o;

   always #5 clk = ~clk;

   wb_arbiter #(.NUM_LANES(NL), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .flush_i           (flush_i),
      .wb_valid          (wb_valid),
      .wb_data           (wb_data),
      .wb_dest           (wb_dest),
      .wb_rob_idx        (wb_rob_idx),
      .br_mispredict     (br_mispredict),
      .br_target         (br_target),
      .prf_we_o          (prf_we_o),
      .prf_waddr_o       (prf_waddr_o),
      .prf_wdata_o       (prf_wdata_o),
      .rob_cmpl_valid_o  (rob_cmpl_valid_o),
      .rob_cmpl_idx_o    (rob_cmpl_idx_o),
      .redirect_valid_o  (redirect_valid_o),
      .redirect_target_o (redirect_target_o),
      .redirect_rob_o    (redirect_rob_o),
      .lane_afull_o      (lane_afull_o),
      .overflow_o        (overflow_o)
   );

   typedef struct {
      int                   cyc;
      int                   n;
      wb_entry_t [NP-1:0]   ent;
      logic [NL-1:0]        afull;
      bit                   ovf;
      bit                   redir;
      logic [63:0]          tgt;
      logic [7:0]           rrob;
   } rec_t;

   wb_entry_t   mq [NL][$];
   int          rr_m = 0;
   bit          ovf_m = 1'b0;
   rec_t        exp_q [$];
   rec_t        mr;
   int          checks = 0;
   int          errors = 0;
   int          edge_n = 0;
   logic [63:0] s_data [NL];
   logic [6:0]  s_dest [NL];
   logic [7:0]  s_rob  [NL];
   logic [63:0] s_tgt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic randomize_lanes();
      for (int l = 0; l < NL; l++) begin
         s_data[l] = {$urandom, $urandom};
         s_dest[l] = 7'($urandom);
         s_rob[l]  = 8'($urandom);
      end
      s_tgt = {$urandom, $urandom};
   endtask

   // Drive one cycle of inputs and predict what the DUT shows after the next posedge.
   task automatic step(input logic [NL-1:0] v, input bit fl, input bit mis);
      rec_t          r;
      wb_entry_t     inp [NL];
      bit [NL-1:0]   g;
      bit [NL-1:0]   byp;
      int            last;
      int            l;
      bit            has;
      bit            b;
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
         inp[i] = '{data: s_data[i], dest: s_dest[i], rob: s_rob[i]};
         wb_data[64*i +: 64]   = s_data[i];
         wb_dest[7*i +: 7]     = s_dest[i];
         wb_rob_idx[8*i +: 8]  = s_rob[i];
         br_target[64*i +: 64] = (i == NL - 1) ? s_tgt : {$urandom, $urandom};
      end
      wb_valid      = v;
      flush_i       = fl;
      br_mispredict = {mis, 7'($urandom)};

      r.cyc   = edge_n + 1;
      r.n     = 0;
      r.ent   = '0;
      r.redir = 1'b0;
      r.tgt   = '0;
      r.rrob  = '0;
      if (fl) begin
         for (int i = 0; i < NL; i++) mq[i].delete();
         rr_m = 0;
      end else begin
         g    = '0;
         byp  = '0;
         last = -1;
         for (int k = 0; k < NL; k++) begin
            l   = (rr_m + k) % NL;
            has = (mq[l].size() > 0);
            b   = 1'b0;
`ifdef WB_ARB_BYPASS_EN
            if (!has && v[l]) begin
               has = 1'b1;
               b   = 1'b1;
            end
`endif
            if (has && r.n < NP) begin
               r.ent[r.n] = b ? inp[l] : mq[l][0];
               r.n++;
               g[l]   = 1'b1;
               byp[l] = b;
               last   = l;
            end
         end
         if (last >= 0) rr_m = (last + 1) % NL;
         for (int i = 0; i < NL; i++) begin
            if (g[i] && !byp[i]) void'(mq[i].pop_front());
            if (v[i] && !byp[i]) begin
               if (mq[i].size() < DEPTH) mq[i].push_back(inp[i]);
               else ovf_m = 1'b1;
            end
         end
         if (v[NL-1] && mis) begin
            r.redir = 1'b1;
            r.tgt   = s_tgt;
            r.rrob  = s_rob[NL-1];
         end
      end
      for (int i = 0; i < NL; i++) r.afull[i] = (mq[i].size() >= DEPTH - 1);
      r.ovf = ovf_m;
      exp_q.push_back(r);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_prf_we"}, 64'(prf_we_o), 64'd0);
      check({tag, "_cmpl_valid"}, 64'(rob_cmpl_valid_o), 64'd0);
      check({tag, "_waddr"}, 64'(prf_waddr_o), 64'd0);
      check({tag, "_cmpl_idx"}, 64'(rob_cmpl_idx_o), 64'd0);
      check({tag, "_redirect_valid"}, 64'(redirect_valid_o), 64'd0);
      check({tag, "_redirect_target"}, redirect_target_o, 64'd0);
      check({tag, "_lane_afull"}, 64'(lane_afull_o), 64'd0);
      check({tag, "_overflow"}, 64'(overflow_o), 64'd0);
   endtask

   // Monitor: compares the DUT outputs after each posedge with the predicted record.
   always @(posedge clk) begin
      #1;
      edge_n++;
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
         mr = exp_q.pop_front();
         check("stale_record", 64'(mr.cyc), 64'(edge_n));
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
         mr = exp_q.pop_front();
         for (int k = 0; k < NP; k++) begin
            if (k < mr.n) begin
               check($sformatf("prf_we[%0d]", k), 64'(prf_we_o[k]), 64'd1);
               check($sformatf("cmpl_valid[%0d]", k), 64'(rob_cmpl_valid_o[k]), 64'd1);
               check($sformatf("waddr[%0d]", k), 64'(prf_waddr_o[7*k +: 7]), 64'(mr.ent[k].dest));
               check($sformatf("wdata[%0d]", k), prf_wdata_o[64*k +: 64], mr.ent[k].data);
               check($sformatf("cmpl_idx[%0d]", k), 64'(rob_cmpl_idx_o[8*k +: 8]), 64'(mr.ent[k].rob));
            end else begin
               check($sformatf("prf_we_idle[%0d]", k), 64'(prf_we_o[k]), 64'd0);
               check($sformatf("cmpl_valid_idle[%0d]", k), 64'(rob_cmpl_valid_o[k]), 64'd0);
            end
         end
         check("lane_afull", 64'(lane_afull_o), 64'(mr.afull));
         check("overflow", 64'(overflow_o), 64'(mr.ovf));
         check("redirect_valid", 64'(redirect_valid_o), 64'(mr.redir));
         if (mr.redir) begin
            check("redirect_target", redirect_target_o, mr.tgt);
            check("redirect_rob", 64'(redirect_rob_o), 64'(mr.rrob));
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         randomize_lanes();
         step('0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [NL-1:0] v;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Single result on lane 2.
      randomize_lanes();
      s_data[2] = 64'h1234;
      s_dest[2] = 7'd5;
      s_rob[2]  = 8'd9;
      step(8'h04, 1'b0, 1'b0);
      idle(3);

      // All lanes at once from rr_ptr = 0.
      step('0, 1'b1, 1'b0);
      randomize_lanes();
      step(8'hFF, 1'b0, 1'b0);
      idle(4);

      // Starve a lane until it overflows, then check overflow survives a flush.
      step('0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         randomize_lanes();
         step(8'b0011_1110, 1'b0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         randomize_lanes();
         step(8'hFF, 1'b0, 1'b0);
      end
      step('0, 1'b1, 1'b0);
      idle(3);

      // Mispredicted branch on lane 7.
      randomize_lanes();
      s_tgt     = 64'h8000;
      s_rob[7]  = 8'h22;
      step(8'h80, 1'b0, 1'b1);
      idle(3);

      // Flush with new results and a mispredict on the same cycle.
      randomize_lanes();
      step(8'hFF, 1'b0, 1'b0);
      randomize_lanes();
      step(8'hFF, 1'b0, 1'b0);
      randomize_lanes();
      step(8'hFF, 1'b1, 1'b1);
      idle(2);

      // Single result on an empty lane 0.
      randomize_lanes();
      step(8'h01, 1'b0, 1'b0);
      idle(3);

      // Randomized traffic with occasional flushes and one asynchronous reset.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            @(negedge clk);
            wb_valid = '0;
            flush_i  = 1'b0;
            rst_n    = 1'b0;
            #1;
            check_reset_outputs("midreset");
            for (int l = 0; l < NL; l++) mq[l].delete();
            rr_m  = 0;
            ovf_m = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         randomize_lanes();
         v = ($urandom_range(0, 1) == 0) ? NL'($urandom) : (NL'($urandom) & NL'($urandom));
         step(v, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
      end
      idle(6);

      @(negedge clk);
      check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
